// File: rtl/hex_display_pkg.sv
// Shared definitions for the multi-digit seven-segment display controller:
// display mode encodings and the active-low segment lookup table.
package hex_display_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_BLINK = 2'b01,
        MODE_COUNT = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, bit 0 = seg a ... bit 6 = seg g
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg7_lookup(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/hex_seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one hex digit
    always_comb begin
        seg_o = seg7_lookup(nib_i);
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment display controller: registered hex value with
// load strobe, hold/blink/count modes, leading-zero blanking and registered
// active-low segment outputs.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [1:0]              mode,
    input  logic                    lzb_en,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic                    wrap
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    mode_e           mode_in;
    mode_e           mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   value_q, value_d;
    logic            phase_q, phase_d;
    logic            wrap_q, wrap_d;
    logic [HW-1:0]   hex_q, hex_d;

    logic            mode_chg;
    logic            tick;
    logic            tick_act;
    logic            show;
    logic [6:0]      seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank;

    // One decoder per digit, fed from the held value
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        hex_seg7_decode u_dec (
            .nib_i (value_q[4*g +: 4]),
            .seg_o (seg[g])
        );
    end

    // Prescaler, value, phase and wrap next-state logic
    always_comb begin
        mode_in  = mode_e'(mode);
        mode_d   = mode_in;
        mode_chg = (mode_in != mode_q);
        tick     = (cnt_q == CNT_MAX);
        // A mode change restarts the tick period, so a coincident tick is dropped
        tick_act = tick && !mode_chg;

        cnt_d = cnt_q + CW'(1);
        if (load || mode_chg || tick) begin
            cnt_d = '0;
        end

        value_d = value_q;
        wrap_d  = 1'b0;
        if (load) begin
            value_d = data_in;
        end else if (tick_act && (mode_q == MODE_COUNT)) begin
            value_d = value_q + VW'(1);
            wrap_d  = &value_q;
        end

        phase_d = phase_q;
        if (load || mode_chg || (mode_q != MODE_BLINK)) begin
            phase_d = 1'b1;
        end else if (tick_act) begin
            phase_d = ~phase_q;
        end
    end

    // Leading-zero mask (scanned from the top digit down) and output patterns
    always_comb begin
        logic run_zero;
        int unsigned idx;
        // Leaving blink mode unblanks on the very next edge, ahead of phase_q
        show     = phase_q || (mode_in != MODE_BLINK);
        run_zero = 1'b1;
        blank    = '0;
        hex_d    = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            idx        = NUM_DIGITS - 1 - k;
            run_zero   = run_zero && (value_q[4*idx +: 4] == 4'h0);
            blank[idx] = lzb_en && run_zero && (idx != 0);
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            hex_d[7*i +: 7] = (!show || blank[i]) ? SEG_BLANK : seg[i];
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            value_q <= '0;
            phase_q <= 1'b1;
            wrap_q  <= 1'b0;
            hex_q   <= '1;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            hex_q   <= hex_d;
        end
    end

    assign hex_out   = hex_q;
    assign value_out = value_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (4 digits, TICK_DIV = 4).
module tb_hex_display_ctrl;

    localparam int ND = 4;
    localparam int TD = 4;

    logic        clk;
    logic        resetn;
    logic        load;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic        lzb_en;
    logic [27:0] hex_out;
    logic [15:0] value_out;
    logic        wrap;

    hex_display_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .data_in   (data_in),
        .mode      (mode),
        .lzb_en    (lzb_en),
        .hex_out   (hex_out),
        .value_out (value_out),
        .wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int unsigned at;
        string       nm;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] B = 7'h7F;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] h4(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {4'h0, d3, d2, d1, d0};
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return {4'h0, hex_out};
            1:       return {16'h0, value_out};
            default: return {31'h0, wrap};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int unsigned at, input string nm, input int sel,
                             input logic [31:0] e);
        exp_t x;
        x.at = at; x.nm = nm; x.sel = sel; x.exp = e;
        sb.push_back(x);
    endtask

    // Monitor: compare every scheduled expectation in the cycle it falls due
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk(sb[i].nm, actual(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                chk({sb[i].nm, "_late"}, 32'hDEAD_BEEF, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d);
        load    = 1'b1;
        data_in = d;
        step();
        load    = 1'b0;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) step();
    endtask

    initial begin
        int unsigned e;
        int unsigned l;
        int unsigned r;
        logic [3:0]  n;

        resetn  = 1'b0;
        load    = 1'b0;
        data_in = '0;
        mode    = 2'b00;
        lzb_en  = 1'b1;
        step();
        step();
        expect_at(cyc, "rst_hex", 0, {4'h0, 28'hFFF_FFFF});
        expect_at(cyc, "rst_val", 1, 32'h0);
        expect_at(cyc, "rst_wrap", 2, 32'h0);

        // Release reset with blanking on
        resetn = 1'b1;
        expect_at(cyc + 1, "rel_hex", 0, h4(B, B, B, 7'h40));
        expect_at(cyc + 1, "rel_val", 1, 32'h0);
        step();
        step();

        do_load(16'h0A05);
        expect_at(cyc, "ld0a05_val", 1, 32'h0A05);
        expect_at(cyc + 1, "ld0a05_hex", 0, h4(B, 7'h08, 7'h40, 7'h12));
        step();

        do_load(16'h0100);
        expect_at(cyc + 1, "lzb0100_hex", 0, h4(B, 7'h79, 7'h40, 7'h40));
        step();
        lzb_en = 1'b0;
        step();
        expect_at(cyc, "lzb_off_hex", 0, h4(7'h40, 7'h79, 7'h40, 7'h40));

        // Decode sweep: every digit carries the same nibble
        for (int d = 0; d < 16; d++) begin
            n = d[3:0];
            do_load({n, n, n, n});
            expect_at(cyc + 1, "decode", 0, h4(SEG[d], SEG[d], SEG[d], SEG[d]));
        end
        step();
        step();

        // Count mode, wrap and leading-zero blanking of the wrapped value
        lzb_en = 1'b1;
        mode   = 2'b10;
        do_load(16'hFFFE);
        e = cyc;
        expect_at(e,      "cnt_val0",  1, 32'hFFFE);
        expect_at(e + 3,  "cnt_val3",  1, 32'hFFFE);
        expect_at(e + 4,  "cnt_val4",  1, 32'hFFFF);
        expect_at(e + 5,  "cnt_hexF",  0, h4(7'h0E, 7'h0E, 7'h0E, 7'h0E));
        expect_at(e + 7,  "wrap_pre",  2, 32'h0);
        expect_at(e + 7,  "cnt_val7",  1, 32'hFFFF);
        expect_at(e + 8,  "cnt_val8",  1, 32'h0000);
        expect_at(e + 8,  "wrap_hit",  2, 32'h1);
        expect_at(e + 9,  "wrap_post", 2, 32'h0);
        expect_at(e + 9,  "cnt_hex0",  0, h4(B, B, B, 7'h40));
        expect_at(e + 12, "cnt_val12", 1, 32'h0001);

        // Load collides with a tick: load wins, period restarts
        wait_until(e + 15);
        do_load(16'h0010);
        expect_at(e + 16, "coll_val",  1, 32'h0010);
        expect_at(e + 16, "coll_wrap", 2, 32'h0);
        expect_at(e + 17, "coll_hex",  0, h4(B, B, 7'h79, 7'h40));
        expect_at(e + 19, "coll_hold", 1, 32'h0010);
        expect_at(e + 20, "coll_inc",  1, 32'h0011);
        wait_until(e + 21);

        // Blink with period 2*TICK_DIV, then leave blink while blanked
        mode   = 2'b01;
        lzb_en = 1'b0;
        do_load(16'h8888);
        l = cyc;
        expect_at(l + 1,  "blk_on1",  0, 32'h0);
        expect_at(l + 4,  "blk_on4",  0, 32'h0);
        expect_at(l + 5,  "blk_off5", 0, {4'h0, 28'hFFF_FFFF});
        expect_at(l + 8,  "blk_off8", 0, {4'h0, 28'hFFF_FFFF});
        expect_at(l + 8,  "blk_val",  1, 32'h8888);
        expect_at(l + 9,  "blk_on9",  0, 32'h0);
        wait_until(l + 13);
        expect_at(l + 13, "blk_off13", 0, {4'h0, 28'hFFF_FFFF});
        mode = 2'b00;
        step();
        expect_at(l + 14, "blk_exit", 0, 32'h0);
        step();

        // Loading zero never pulses wrap
        do_load(16'h0000);
        expect_at(cyc, "ld0_wrap", 2, 32'h0);
        expect_at(cyc, "ld0_val",  1, 32'h0);
        step();

        // Asynchronous reset in the middle of counting
        mode = 2'b10;
        do_load(16'h1234);
        e = cyc;
        expect_at(e + 4, "ar_val4", 1, 32'h1235);
        wait_until(e + 5);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_hex",  {4'h0, hex_out}, {4'h0, 28'hFFF_FFFF});
        chk("arst_val",  {16'h0, value_out}, 32'h0);
        chk("arst_wrap", {31'h0, wrap}, 32'h0);
        step();
        step();
        resetn = 1'b1;
        r = cyc;
        expect_at(r + 4, "post_rst_val4", 1, 32'h0000);
        expect_at(r + 5, "post_rst_val5", 1, 32'h0001);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 40 && sb.size() != 0; k++) step();
        while (sb.size() != 0) begin
            chk({sb[0].nm, "_timeout"}, 32'hDEAD_BEEF, sb[0].exp);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
